// File: rtl/in_ep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : in_ep_ctrl_if
//  Description : SIE-facing and FIFO-facing signal bundle of the IN endpoint
//                controller. The slave modport is the controller's view; the
//                master modport is the view of the SIE/FIFO environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface in_ep_ctrl_if #(
  parameter int NAK_CNT_WIDTH = 8
);

  // SIE side
  logic [3:0]               endp_i;
  logic                     in_req_i;
  logic                     in_ready_i;
  logic                     in_data_ack_i;
  logic                     out_valid_i;
  logic                     out_ready_i;
  logic [7:0]               in_data_o;
  logic                     in_valid_o;
  logic                     in_toggle_o;

  // FIFO A (bulk data)
  logic                     epa_in_req_o;
  logic                     epa_in_ready_o;
  logic                     epa_in_data_ack_o;
  logic                     epa_out_valid_o;
  logic                     epa_out_ready_o;
  logic [7:0]               epa_in_data_i;
  logic                     epa_in_valid_i;
  logic                     epa_in_empty_i;
  logic [NAK_CNT_WIDTH-1:0] epa_nak_cnt_o;

  // FIFO B (interrupt)
  logic                     epb_in_req_o;
  logic                     epb_in_ready_o;
  logic                     epb_in_data_ack_o;
  logic                     epb_out_valid_o;
  logic                     epb_out_ready_o;
  logic [7:0]               epb_in_data_i;
  logic                     epb_in_valid_i;
  logic                     epb_in_empty_i;
  logic [NAK_CNT_WIDTH-1:0] epb_nak_cnt_o;

  modport slave (
    input  endp_i, in_req_i, in_ready_i, in_data_ack_i, out_valid_i, out_ready_i,
    output in_data_o, in_valid_o, in_toggle_o,
    output epa_in_req_o, epa_in_ready_o, epa_in_data_ack_o, epa_out_valid_o, epa_out_ready_o,
    input  epa_in_data_i, epa_in_valid_i, epa_in_empty_i,
    output epa_nak_cnt_o,
    output epb_in_req_o, epb_in_ready_o, epb_in_data_ack_o, epb_out_valid_o, epb_out_ready_o,
    input  epb_in_data_i, epb_in_valid_i, epb_in_empty_i,
    output epb_nak_cnt_o
  );

  modport master (
    output endp_i, in_req_i, in_ready_i, in_data_ack_i, out_valid_i, out_ready_i,
    input  in_data_o, in_valid_o, in_toggle_o,
    input  epa_in_req_o, epa_in_ready_o, epa_in_data_ack_o, epa_out_valid_o, epa_out_ready_o,
    output epa_in_data_i, epa_in_valid_i, epa_in_empty_i,
    input  epa_nak_cnt_o,
    input  epb_in_req_o, epb_in_ready_o, epb_in_data_ack_o, epb_out_valid_o, epb_out_ready_o,
    output epb_in_data_i, epb_in_valid_i, epb_in_empty_i,
    input  epb_nak_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/in_ep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : in_ep_ctrl
//  Description : USB IN endpoint controller. Routes an IN token to one of two
//                FIFOs (A = bulk, B = interrupt), muxes the selected FIFO's
//                data to the SIE, forwards SIE strobes to that FIFO only,
//                keeps per-endpoint DATA0/DATA1 toggles and counts requests
//                that found the FIFO empty (NAKs).
//  Revision    : 1.0  initial release
// ============================================================================
module in_ep_ctrl #(
  parameter logic [3:0] EPA_NUM       = 4'd1,
  parameter logic [3:0] EPB_NUM       = 4'd2,
  parameter int         HS_TIMEOUT    = 256,
  parameter int         NAK_CNT_WIDTH = 8
) (
  input  wire logic     clk_i,
  input  wire logic     rstn_i,
  input  wire logic     bus_reset_i,
  in_ep_ctrl_if.slave   bus
);

  localparam int c_HS_CNT_W = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
  localparam logic [c_HS_CNT_W-1:0] c_HS_LAST = c_HS_CNT_W'(HS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_HS   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } sel_t;

  state_t                   r_state;
  sel_t                     r_sel;
  logic                     r_in_req_q;
  logic [c_HS_CNT_W-1:0]    r_hs_cnt;
  logic                     r_epa_tgl;
  logic                     r_epb_tgl;
  logic [NAK_CNT_WIDTH-1:0] r_epa_nak;
  logic [NAK_CNT_WIDTH-1:0] r_epb_nak;
  logic                     r_epa_in_req;
  logic                     r_epb_in_req;

  logic                     w_start;
  logic                     w_active;
  logic                     w_fwd_a;
  logic                     w_fwd_b;
  logic                     w_hs_exit;
  logic                     w_ack;
  sel_t                     w_start_sel;
  sel_t                     w_sel_nxt;

  // Rising edge of the SIE request marks a new IN token
  assign w_start   = bus.in_req_i & ~r_in_req_q;
  assign w_active  = (r_state != ST_IDLE);
  assign w_fwd_a   = w_active && (r_sel == SEL_A);
  assign w_fwd_b   = w_active && (r_sel == SEL_B);

  // Handshake phase ends on any SIE handshake strobe or when the window expires
  assign w_hs_exit = (r_state == ST_HS) &&
                     (bus.out_valid_i || bus.out_ready_i || (r_hs_cnt == c_HS_LAST));

  // A successful ACK; a new token in the same cycle abandons the old transaction
  assign w_ack     = (r_state == ST_HS) && bus.in_data_ack_i && bus.out_ready_i && !w_start;

  // Endpoint decode of the token; A has priority if both numbers coincide
  always_comb begin
    w_start_sel = SEL_NONE;
    if (bus.endp_i == EPA_NUM) begin
      w_start_sel = SEL_A;
    end else if (bus.endp_i == EPB_NUM) begin
      w_start_sel = SEL_B;
    end
  end

  // Selection that will be in force after this clock edge
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_start) begin
      w_sel_nxt = w_start_sel;
    end else if (w_hs_exit) begin
      w_sel_nxt = SEL_NONE;
    end
  end

  // Transaction FSM: state, selection, request edge detector and handshake timer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_NONE;
      r_in_req_q <= 1'b0;
      r_hs_cnt   <= '0;
    end else if (bus_reset_i) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_NONE;
      r_in_req_q <= 1'b0;
      r_hs_cnt   <= '0;
    end else begin
      r_in_req_q <= bus.in_req_i;
      r_sel      <= w_sel_nxt;
      if (w_start) begin
        r_state  <= ST_DATA;
        r_hs_cnt <= '0;
      end else begin
        case (r_state)
          ST_DATA: begin
            if (!bus.in_req_i) begin
              r_state  <= ST_HS;
              r_hs_cnt <= '0;
            end
          end
          ST_HS: begin
            if (w_hs_exit) begin
              r_state <= ST_IDLE;
            end else begin
              r_hs_cnt <= r_hs_cnt + c_HS_CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Registered FIFO read requests, one cycle behind the SIE request
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_epa_in_req <= 1'b0;
      r_epb_in_req <= 1'b0;
    end else if (bus_reset_i) begin
      r_epa_in_req <= 1'b0;
      r_epb_in_req <= 1'b0;
    end else begin
      r_epa_in_req <= bus.in_req_i && (w_sel_nxt == SEL_A);
      r_epb_in_req <= bus.in_req_i && (w_sel_nxt == SEL_B);
    end
  end

  // DATA0/DATA1 toggles advance only on an ACKed transaction of that endpoint
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_epa_tgl <= 1'b0;
      r_epb_tgl <= 1'b0;
    end else if (bus_reset_i) begin
      r_epa_tgl <= 1'b0;
      r_epb_tgl <= 1'b0;
    end else if (w_ack) begin
      if (r_sel == SEL_A) begin
        r_epa_tgl <= ~r_epa_tgl;
      end
      if (r_sel == SEL_B) begin
        r_epb_tgl <= ~r_epb_tgl;
      end
    end
  end

  // Saturating counts of tokens that found their FIFO empty
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_epa_nak <= '0;
      r_epb_nak <= '0;
    end else if (bus_reset_i) begin
      r_epa_nak <= '0;
      r_epb_nak <= '0;
    end else if (w_start) begin
      if ((w_start_sel == SEL_A) && bus.epa_in_empty_i && (r_epa_nak != '1)) begin
        r_epa_nak <= r_epa_nak + NAK_CNT_WIDTH'(1);
      end
      if ((w_start_sel == SEL_B) && bus.epb_in_empty_i && (r_epb_nak != '1)) begin
        r_epb_nak <= r_epb_nak + NAK_CNT_WIDTH'(1);
      end
    end
  end

  // Data path to the SIE: selected FIFO only, zero when idle or unrouted
  assign bus.in_data_o   = w_fwd_a ? bus.epa_in_data_i :
                           w_fwd_b ? bus.epb_in_data_i : 8'd0;
  assign bus.in_valid_o  = (w_fwd_a && bus.epa_in_valid_i) ||
                           (w_fwd_b && bus.epb_in_valid_i);
  assign bus.in_toggle_o = (r_sel == SEL_A) ? r_epa_tgl :
                           (r_sel == SEL_B) ? r_epb_tgl : 1'b0;

  // Strobes to FIFO A
  assign bus.epa_in_req_o      = r_epa_in_req;
  assign bus.epa_in_ready_o    = w_fwd_a && bus.in_ready_i;
  assign bus.epa_in_data_ack_o = w_fwd_a && bus.in_data_ack_i;
  assign bus.epa_out_valid_o   = w_fwd_a && bus.out_valid_i;
  assign bus.epa_out_ready_o   = w_fwd_a && bus.out_ready_i;
  assign bus.epa_nak_cnt_o     = r_epa_nak;

  // Strobes to FIFO B
  assign bus.epb_in_req_o      = r_epb_in_req;
  assign bus.epb_in_ready_o    = w_fwd_b && bus.in_ready_i;
  assign bus.epb_in_data_ack_o = w_fwd_b && bus.in_data_ack_i;
  assign bus.epb_out_valid_o   = w_fwd_b && bus.out_valid_i;
  assign bus.epb_out_ready_o   = w_fwd_b && bus.out_ready_i;
  assign bus.epb_nak_cnt_o     = r_epb_nak;

endmodule
`default_nettype wire

// File: tb/tb_in_ep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_in_ep_ctrl
//  Description : Self-checking bench for in_ep_ctrl. Transactions are issued
//                by phase (token, data, handshake) and every cycle the outputs
//                are compared against a transaction-level model of routing,
//                toggles and NAK counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_in_ep_ctrl;

  localparam int c_NAKW    = 8;
  localparam int c_NAK_MAX = (1 << c_NAKW) - 1;
  localparam int c_HS_TMO  = 256;
  localparam int K_ACK = 0, K_NAK = 1, K_ABT = 2, K_TMO = 3;

  logic clk = 1'b0;
  logic rstn;
  logic bus_reset;

  always #5 clk = ~clk;

  in_ep_ctrl_if #(.NAK_CNT_WIDTH(c_NAKW)) bus ();

  in_ep_ctrl #(
    .EPA_NUM      (4'd1),
    .EPB_NUM      (4'd2),
    .HS_TIMEOUT   (c_HS_TMO),
    .NAK_CNT_WIDTH(c_NAKW)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .bus_reset_i(bus_reset),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: which endpoint owns the bus, its toggles, NAK counts
  bit m_active;
  int m_sel;
  bit m_req [2];
  bit m_tgl [2];
  int m_nak [2];

  function automatic int ep_idx(input logic [3:0] ep);
    if (ep == 4'd1) return 0;
    if (ep == 4'd2) return 1;
    return -1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    m_sel    = -1;
    m_req[0] = 1'b0; m_req[1] = 1'b0;
    m_tgl[0] = 1'b0; m_tgl[1] = 1'b0;
    m_nak[0] = 0;    m_nak[1] = 0;
  endtask

  task automatic check_outputs(input string ph);
    bit         sa, sb;
    logic [7:0] e_data;
    logic       e_valid, e_tgl;
    logic [9:0] e_str, o_str;
    #1;
    sa      = m_active && (m_sel == 0);
    sb      = m_active && (m_sel == 1);
    e_data  = sa ? bus.epa_in_data_i : (sb ? bus.epb_in_data_i : 8'd0);
    e_valid = (sa && bus.epa_in_valid_i) || (sb && bus.epb_in_valid_i);
    e_tgl   = (m_sel == 0) ? m_tgl[0] : ((m_sel == 1) ? m_tgl[1] : 1'b0);
    e_str   = {m_req[0], sa && bus.in_ready_i, sa && bus.in_data_ack_i,
               sa && bus.out_valid_i, sa && bus.out_ready_i,
               m_req[1], sb && bus.in_ready_i, sb && bus.in_data_ack_i,
               sb && bus.out_valid_i, sb && bus.out_ready_i};
    o_str   = {bus.epa_in_req_o, bus.epa_in_ready_o, bus.epa_in_data_ack_o,
               bus.epa_out_valid_o, bus.epa_out_ready_o,
               bus.epb_in_req_o, bus.epb_in_ready_o, bus.epb_in_data_ack_o,
               bus.epb_out_valid_o, bus.epb_out_ready_o};
    check_val({ph, "/in_data"},   32'(bus.in_data_o),     32'(e_data));
    check_val({ph, "/in_valid"},  32'(bus.in_valid_o),    32'(e_valid));
    check_val({ph, "/in_toggle"}, 32'(bus.in_toggle_o),   32'(e_tgl));
    check_val({ph, "/strobes"},   32'(o_str),             32'(e_str));
    check_val({ph, "/nak_a"},     32'(bus.epa_nak_cnt_o), 32'(m_nak[0]));
    check_val({ph, "/nak_b"},     32'(bus.epb_nak_cnt_o), 32'(m_nak[1]));
  endtask

  // Random background: FIFO contents, endpoint bus noise, ready and lone ACK
  task automatic rand_inputs();
    bus.endp_i         = 4'($urandom_range(0, 15));
    bus.in_ready_i     = 1'($urandom_range(0, 1));
    bus.in_data_ack_i  = 1'($urandom_range(0, 1));
    bus.out_valid_i    = 1'b0;
    bus.out_ready_i    = 1'b0;
    bus.epa_in_data_i  = 8'($urandom);
    bus.epa_in_valid_i = 1'($urandom_range(0, 1));
    bus.epa_in_empty_i = 1'($urandom_range(0, 1));
    bus.epb_in_data_i  = 8'($urandom);
    bus.epb_in_valid_i = 1'($urandom_range(0, 1));
    bus.epb_in_empty_i = 1'($urandom_range(0, 1));
  endtask

  task automatic cyc(input string ph);
    check_outputs(ph);
    @(posedge clk);
  endtask

  task automatic txn(input logic [3:0] ep, input bit empty, input int nbytes,
                     input int kind, input int hs_wait);
    int idx;
    int n_gap;
    idx = ep_idx(ep);
    // token phase
    @(negedge clk);
    rand_inputs();
    bus.endp_i      = ep;
    bus.in_req_i    = 1'b1;
    bus.out_valid_i = 1'($urandom_range(0, 1));
    bus.out_ready_i = 1'($urandom_range(0, 1));
    if (idx == 0) bus.epa_in_empty_i = empty;
    if (idx == 1) bus.epb_in_empty_i = empty;
    cyc("start");
    m_active = 1'b1;
    m_sel    = idx;
    m_req[0] = (idx == 0);
    m_req[1] = (idx == 1);
    if (idx >= 0 && empty && m_nak[idx] < c_NAK_MAX) m_nak[idx]++;
    // data phase
    for (int k = 0; k < nbytes; k++) begin
      @(negedge clk);
      rand_inputs();
      cyc("data");
    end
    @(negedge clk);
    rand_inputs();
    bus.in_req_i = 1'b0;
    cyc("eod");
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
    // handshake phase
    if (kind == K_TMO) begin
      for (int k = 0; k < c_HS_TMO; k++) begin
        @(negedge clk);
        rand_inputs();
        cyc("hs_tmo");
      end
      m_active = 1'b0;
      m_sel    = -1;
    end else begin
      for (int k = 0; k < hs_wait; k++) begin
        @(negedge clk);
        rand_inputs();
        cyc("hs_wait");
      end
      if (kind != K_ABT) begin
        @(negedge clk);
        rand_inputs();
        if (kind == K_ACK) begin
          bus.in_data_ack_i = 1'b1;
          bus.out_ready_i   = 1'b1;
        end else if ($urandom_range(0, 1) == 0) begin
          bus.out_valid_i = 1'b1;
        end else begin
          bus.in_data_ack_i = 1'b0;
          bus.out_ready_i   = 1'b1;
        end
        cyc("hs_end");
        if (kind == K_ACK && idx >= 0) m_tgl[idx] = ~m_tgl[idx];
        m_active = 1'b0;
        m_sel    = -1;
      end
    end
    // idle gap (none after an abandoned handshake so the next token lands in it)
    n_gap = (kind == K_ABT) ? 0 : $urandom_range(0, 2);
    for (int k = 0; k < n_gap; k++) begin
      @(negedge clk);
      rand_inputs();
      cyc("gap");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, kind;
    logic [3:0] ep;

    model_clear();
    rstn      = 1'b0;
    bus_reset = 1'b0;
    bus.in_req_i = 1'b0;
    rand_inputs();
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rand_inputs();
    cyc("idle");

    // Bulk transfer of 3 bytes with ACK, then a second one to observe DATA1
    txn(4'd1, 1'b0, 3, K_ACK, 1);
    txn(4'd1, 1'b0, 2, K_ACK, 0);
    // Three empty interrupt requests
    for (int i = 0; i < 3; i++) txn(4'd2, 1'b1, 0, K_NAK, 1);
    check_val("nak_b_after_three", 32'(bus.epb_nak_cnt_o), 32'(m_nak[1]));
    // Unrouted endpoint
    txn(4'd5, 1'b1, 2, K_ACK, 0);
    // Handshake timeout, then a token for B abandons a pending handshake on A
    txn(4'd1, 1'b0, 1, K_TMO, 0);
    txn(4'd1, 1'b0, 1, K_ABT, 3);
    txn(4'd2, 1'b0, 1, K_ACK, 0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 3);
      ep = (r == 0) ? 4'd1 : (r == 1) ? 4'd2 : (r == 2) ? 4'($urandom_range(3, 15)) : 4'd0;
      r = $urandom_range(0, 9);
      kind = (r < 5) ? K_ACK : (r < 7) ? K_NAK : (r < 9) ? K_ABT : K_TMO;
      txn(ep, 1'($urandom_range(0, 1)), $urandom_range(0, 4), kind, $urandom_range(0, 5));
    end

    // Saturate the FIFO A NAK counter and push past it
    while (m_nak[0] < c_NAK_MAX) txn(4'd1, 1'b1, 0, K_NAK, 0);
    txn(4'd1, 1'b1, 0, K_NAK, 0);
    txn(4'd1, 1'b1, 0, K_NAK, 0);
    check_val("nak_a_saturated", 32'(bus.epa_nak_cnt_o), 32'(c_NAK_MAX));

    // Bus reset during a pending handshake, colliding with a token and an ACK
    txn(4'd2, 1'b1, 1, K_ABT, 2);
    @(negedge clk);
    rand_inputs();
    bus_reset         = 1'b1;
    bus.endp_i        = 4'd1;
    bus.in_req_i      = 1'b1;
    bus.in_data_ack_i = 1'b1;
    bus.out_ready_i   = 1'b1;
    cyc("busrst");
    model_clear();
    @(negedge clk);
    bus_reset    = 1'b0;
    rand_inputs();
    bus.in_req_i = 1'b0;
    cyc("post_busrst");
    txn(4'd1, 1'b0, 1, K_ACK, 0);

    // Asynchronous reset in the middle of a data phase
    @(negedge clk);
    rand_inputs();
    bus.endp_i   = 4'd1;
    bus.in_req_i = 1'b1;
    bus.epa_in_empty_i = 1'b1;
    cyc("rst_start");
    m_active = 1'b1; m_sel = 0; m_req[0] = 1'b1; m_req[1] = 1'b0;
    if (m_nak[0] < c_NAK_MAX) m_nak[0]++;
    @(negedge clk);
    rand_inputs();
    bus.in_ready_i     = 1'b1;
    bus.epa_in_valid_i = 1'b1;
    check_outputs("rst_data");
    #1;
    rstn = 1'b0;
    model_clear();
    check_outputs("rst_async");
    @(negedge clk);
    bus.in_req_i = 1'b0;
    rstn = 1'b1;
    rand_inputs();
    cyc("post_rst");
    txn(4'd2, 1'b0, 2, K_ACK, 1);
    @(negedge clk);
    rand_inputs();
    cyc("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/in_ep_ctrl.md
IN_EP_CTRL -- requirements
Module: in_ep_ctrl

Interface
REQ-001 SHALL have parameter EPA_NUM, default 4'd1, endpoint number routed to FIFO A (bulk data).
REQ-002 SHALL have parameter EPB_NUM, default 4'd2, endpoint number routed to FIFO B (interrupt).
REQ-003 SHALL have parameter HS_TIMEOUT, default 'd256, clk_i cycles allowed for the handshake phase.
REQ-004 SHALL have parameter NAK_CNT_WIDTH, default 'd8, width of the per-endpoint NAK counters.
REQ-005 SHALL use one clock, clk_i; reset is rstn_i, asynchronous, active-low; all state is in the clk_i domain.
REQ-006 SHALL have these ports (name direction width meaning):
clk_i  in  1  12MHz*BIT_SAMPLES clock
rstn_i  in  1  async active-low reset
bus_reset_i  in  1  USB bus reset, synchronous clear
endp_i  in  4  token endpoint, valid on in_req_i rise
in_req_i, in_ready_i, in_data_ack_i, out_valid_i, out_ready_i  in  1 each  from SIE
in_data_o  out  8  muxed IN data to SIE
in_valid_o  out  1  muxed IN valid to SIE
in_toggle_o  out  1  DATA0(0)/DATA1(1) for current transaction
epa_/epb_ in_req_o, in_ready_o, in_data_ack_o, out_valid_o, out_ready_o  out  1 each  to FIFO A/B
epa_/epb_ in_data_i  in  8; in_valid_i  in  1; in_empty_i  in  1  from FIFO A/B
epa_/epb_ nak_cnt_o  out  NAK_CNT_WIDTH  saturating empty-request count

Function
REQ-007 SHALL implement states ST_IDLE, ST_DATA, ST_HS; selection sel in {NONE, A, B}.
REQ-008 SHALL detect start as in_req_i=1 with registered in_req_q=0.
REQ-009 On start in any state: endp_i==EPA_NUM -> sel=A; else endp_i==EPB_NUM -> sel=B; else sel=NONE; state -> ST_DATA next cycle. EPA wins if EPA_NUM==EPB_NUM.
REQ-010 epX_in_req_o SHALL be registered: 1 from the cycle after start while in_req_i=1 and sel=X; 0 otherwise (1-cycle latency).
REQ-011 in_data_o/in_valid_o SHALL combinationally mirror the selected FIFO's data/valid while state!=ST_IDLE; 8'd0/0 when sel=NONE or ST_IDLE.
REQ-012 in_ready_i, in_data_ack_i, out_valid_i, out_ready_i SHALL be forwarded combinationally only to the selected FIFO while state!=ST_IDLE; unselected FIFO outputs 0.
REQ-013 ST_DATA -> ST_HS when in_req_i=0; HS counter cleared.
REQ-014 ST_HS -> ST_IDLE when out_valid_i=1 or out_ready_i=1 (forwarded that cycle), or when HS counter reaches HS_TIMEOUT-1; sel -> NONE on entering ST_IDLE.
REQ-015 Start while in ST_HS SHALL abandon the old transaction (no toggle flip) and begin the new one per REQ-009.
REQ-016 Per-endpoint toggle bits SHALL flip exactly once per transaction when state=ST_HS, in_data_ack_i=1, out_ready_i=1 for the selected endpoint; no flip on timeout or out_valid_i alone.
REQ-017 in_toggle_o SHALL equal the selected endpoint's toggle; 0 when sel=NONE.
REQ-018 epX_nak_cnt_o SHALL increment by 1 when a start selects X with epX_in_empty_i=1; saturates at all-ones.
REQ-019 bus_reset_i=1 SHALL synchronously force ST_IDLE, sel=NONE, toggles=0, NAK counters=0, in_req_q=0; overrides all other events that cycle.

Reset
REQ-020 rstn_i=0 SHALL asynchronously force ST_IDLE, sel=NONE, in_req_q=0, HS counter=0, both toggles=0, both NAK counters=0; all outputs 0.
REQ-021 Reset mid-transaction SHALL drop all forwarded strobes to 0 immediately; no toggle flip is recorded.

Verification
REQ-022 endp_i=1, in_req_i rise, FIFO A holds 3 bytes, SIE consumes 3 bytes, ACK (in_data_ack_i=1, out_ready_i=1) -> epa_in_req_o high 1 cycle after rise, 3 bytes on in_data_o, in_toggle_o 0 then 1 in next transaction, epb_* strobes stay 0.
REQ-023 endp_i=2 with epb_in_empty_i=1, three requests -> epb_nak_cnt_o=3, in_valid_o=0, epb toggle unchanged.
REQ-024 endp_i=5 request -> sel=NONE, in_valid_o=0, in_data_o=0, no FIFO strobes, no counter change.
REQ-025 endp_i=1 data phase, no handshake for HS_TIMEOUT cycles -> ST_IDLE after 256 cycles, toggle unchanged; new request on endp 2 mid-HS -> abort, sel=B next cycle.
REQ-026 Assert NAK counter to 255 then one more empty request -> stays 255; bus_reset_i pulse -> counters 0, toggles 0, ST_IDLE; rstn_i low mid-ST_DATA -> all outputs 0 immediately.
